mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data-port grants while the fetch port waits.
REQ-002 SHALL have ports clk input 1 (system clock) and rst input 1 (reset: synchronous, active-high).
REQ-003 SHALL have rdy_in input 1: global ready; low freezes the block.
REQ-004 SHALL have if_req input 1 and if_addr input 32: instruction-fetch request and byte address; every fetch is 4 bytes.
REQ-005 SHALL have if_done output 1 and if_data output 32: one-cycle done pulse and fetched word, little-endian.
REQ-006 SHALL have mem_req input 1, mem_we input 1, mem_addr input 32, mem_wdata input 32 and mem_len input 2: data request, write flag, address, store data, and size (01 byte, 10 half, 11 word, 00 treated as 01).
REQ-007 SHALL have mem_done output 1 and mem_rdata output 32: one-cycle done pulse and load data, zero-extended.
REQ-008 SHALL have ram_a output 32, ram_dout output 8, ram_wr output 1 and ram_din input 8: byte-serial RAM port; read data arrives one cycle after its address.
REQ-009 SHALL have busy output 1, high whenever the FSM is not IDLE.

Function
REQ-010 SHALL implement the states IDLE, XFER, TAIL and DONE.
REQ-011 In IDLE with any request pending, SHALL latch the winner's address, length, write flag and data, clear byte counter k, and go to XFER.
REQ-012 SHALL apply fixed priority: mem beats if when both request in the same cycle.
REQ-013 In XFER, SHALL drive ram_a = base+k mod 2^32 and increment k each cycle.
REQ-014 For writes in XFER, SHALL drive ram_wr=1 and ram_dout = data byte k.
REQ-015 For reads in XFER, SHALL drive ram_wr=0 and capture ram_din into result byte k-1 when k>0.
REQ-016 After the last byte is issued in XFER, writes SHALL go to DONE and reads SHALL go to TAIL.
REQ-017 In TAIL, SHALL capture the final byte with ram_wr=0, then go to DONE.
REQ-018 In DONE, SHALL pulse if_done or mem_done for exactly one cycle with data valid in the same cycle, then return to IDLE.
REQ-019 Latency from the accepting edge to the done pulse SHALL be n+1 cycles for a write and n+2 cycles for a read, where n is the byte count.
REQ-020 Outside DONE, if_data and mem_rdata SHALL hold their last value; unused upper bytes of mem_rdata SHALL be 0.
REQ-021 SHALL ignore a request dropped mid-transfer: the transfer completes and the done pulse is still issued.
REQ-022 After a done pulse, SHALL spend at least one IDLE cycle before the next grant; back-to-back transfers are therefore spaced by the DONE and IDLE cycles.
REQ-023 While rdy_in=0, SHALL freeze state, k, latched fields and the starvation counter, and force ram_wr=0.
REQ-024 When rdy_in returns high, SHALL resume on the same byte.
REQ-025 Outside XFER writes, ram_wr SHALL be 0 and ram_a SHALL hold its last value.

Reset
REQ-026 On rst at a clock edge, including mid-transfer, SHALL enter IDLE and abort any transfer without a done pulse.
REQ-027 On reset, ram_wr, if_done, mem_done and busy SHALL be 0.
REQ-028 On reset, ram_a, ram_dout, if_data, mem_rdata, k and the starvation counter SHALL be 0.
REQ-029 rst SHALL override rdy_in.

Configuration
REQ-030 With ARB_STARVE_GUARD_EN defined, SHALL count consecutive mem grants taken while if_req=1.
REQ-031 With ARB_STARVE_GUARD_EN defined, when the count reaches STARVE_LIMIT the next IDLE decision SHALL grant if even if mem_req=1.
REQ-032 With ARB_STARVE_GUARD_EN defined, SHALL clear the count on any if grant or when if_req=0 in IDLE.
REQ-033 Without ARB_STARVE_GUARD_EN, SHALL use strict mem priority and include no counter.

Verification
REQ-034 if_req, addr 0x100, RAM holds 13 00 00 00 -> ram_a runs 0x100..0x103; if_done at accept+6; if_data=0x00000013.
REQ-035 mem write, len 11, addr 0x200, data 0xDEADBEEF -> ram_wr high 4 cycles with bytes EF BE AD DE at 0x200..0x203; mem_done at accept+5.
REQ-036 mem read, len 10, addr 0xFFFFFFFF -> ram_a runs 0xFFFFFFFF then 0x00000000; mem_done at accept+4; upper 16 bits of mem_rdata = 0.
REQ-037 if_req and mem_req held continuously with guard on, STARVE_LIMIT=4 -> grant order mem,mem,mem,mem,if,mem...; with guard off -> if never granted.
REQ-038 rdy_in low for 3 cycles during a word read -> ram_wr=0 and done delayed by exactly 3 cycles with correct data.
REQ-039 rst asserted in the second byte of a word write -> next cycle ram_wr=0, busy=0, no mem_done.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority (data over fetch) byte-serial RAM arbiter with one-cycle done pulses.
// Define ARB_STARVE_GUARD_EN to cap consecutive data grants while a fetch is waiting.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_len,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StXfer, StTail, StDone} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_base, r_wdata, r_buf, r_if_data, r_mem_rdata, r_ram_a;
  logic [7:0]  r_ram_dout;
  logic [2:0]  r_k, r_n;
  logic        r_we, r_is_if;

  logic        w_grant_if, w_grant_mem, w_starved, w_capture, w_active;
  logic [2:0]  w_len_n;
  logic [1:0]  w_idx;
  logic [31:0] w_buf_nxt, w_cur_a;
  logic [7:0]  w_cur_byte;

  always_comb begin
    case (mem_len)
      2'b10:   w_len_n = 3'd2;
      2'b11:   w_len_n = 3'd4;
      default: w_len_n = 3'd1;
    endcase
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);
  logic [CntW-1:0] r_starve;

  assign w_starved = (32'(r_starve) >= STARVE_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (rdy_in && (r_state == StIdle)) begin
      if (w_grant_if || !if_req) begin
        r_starve <= '0;
      end else if (w_grant_mem) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end
`else
  assign w_starved = 1'b0;
`endif

  assign w_grant_mem = mem_req && !(if_req && w_starved);
  assign w_grant_if  = if_req && !w_grant_mem;

  assign w_active   = (r_state == StXfer) && rdy_in;
  assign w_cur_a    = r_base + 32'(r_k);
  assign w_cur_byte = r_wdata[8*r_k[1:0] +: 8];
  assign w_idx      = r_k[1:0] - 2'd1;
  assign w_capture  = ((r_state == StXfer) && !r_we && (r_k != 3'd0)) || (r_state == StTail);

  // Read data lags its address by a cycle, so byte k-1 is captured while byte k is addressed.
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_capture) begin
      w_buf_nxt[8*w_idx +: 8] = ram_din;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_grant_mem || w_grant_if) w_state_nxt = StXfer;
      StXfer: if (r_k == r_n - 3'd1) w_state_nxt = r_we ? StDone : StTail;
      StTail: w_state_nxt = StDone;
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_k         <= '0;
      r_n         <= '0;
      r_we        <= 1'b0;
      r_is_if     <= 1'b0;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (w_grant_mem || w_grant_if) begin
            r_is_if <= w_grant_if;
            r_base  <= w_grant_if ? if_addr : mem_addr;
            r_we    <= w_grant_mem && mem_we;
            r_wdata <= mem_wdata;
            r_n     <= w_grant_if ? 3'd4 : w_len_n;
            r_k     <= '0;
            r_buf   <= '0;
          end
        end
        StXfer: begin
          r_k     <= r_k + 3'd1;
          r_buf   <= w_buf_nxt;
          r_ram_a <= w_cur_a;
          if (r_we) r_ram_dout <= w_cur_byte;
        end
        StTail: begin
          r_buf <= w_buf_nxt;
          if (r_is_if) r_if_data <= w_buf_nxt;
          else         r_mem_rdata <= w_buf_nxt;
        end
        default: ;
      endcase
    end
  end

  // A stalled XFER keeps showing the last issued address so the pending read byte stays valid.
  assign ram_a     = w_active ? w_cur_a : r_ram_a;
  assign ram_wr    = w_active && r_we;
  assign ram_dout  = ((r_state == StXfer) && r_we) ? w_cur_byte : r_ram_dout;
  assign busy      = (r_state != StIdle);
  assign if_done   = (r_state == StDone) && r_is_if && rdy_in;
  assign mem_done  = (r_state == StDone) && !r_is_if && rdy_in;
  assign if_data   = r_if_data;
  assign mem_rdata = r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized single-port transfers
// checked against a byte-array RAM model and latency/trace rules.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy_in;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        if_done, mem_done, ram_wr, busy;
  logic [31:0] if_data, mem_rdata, ram_a;
  logic [7:0]  ram_dout, ram_din;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the last run_xfer call.
  int          o_lat, o_stall_wr, o_wrong_done;
  logic [31:0] o_a[$];
  logic        o_wr[$];
  logic [7:0]  o_dout[$];
  logic [31:0] o_if_data, o_mem_rdata;

  // Model of the last delivered fetch / load words.
  logic [31:0] g_if, g_mem;

  logic [7:0] ram [0:1023];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy_in    (rdy_in),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_data   (if_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_len   (mem_len),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_a     (ram_a),
    .ram_dout  (ram_dout),
    .ram_wr    (ram_wr),
    .ram_din   (ram_din),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
    ram_din <= ram[ram_a[9:0]];
  end

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
    logic [31:0] v;
    logic [31:0] a;
    v = '0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      v[8*i +: 8] = ram[a[9:0]];
    end
    return v;
  endfunction

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'b11) ? 4 : (len == 2'b10) ? 2 : 1;
  endfunction

  // Issue one request for a single cycle, then scramble inputs and record per-cycle outputs.
  task automatic run_xfer(input bit use_mem, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] len,
                          input int stall_at, input int stall_n);
    o_lat = -1; o_stall_wr = 0; o_wrong_done = 0;
    o_a.delete(); o_wr.delete(); o_dout.delete();
    @(posedge clk); #1;
    if_req = !use_mem; mem_req = use_mem; mem_we = we;
    if_addr = addr; mem_addr = addr; mem_wdata = wd; mem_len = len; rdy_in = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    mem_addr = $urandom; if_addr = $urandom; mem_wdata = $urandom;
    mem_we = 1'($urandom); mem_len = 2'($urandom);
    for (int c = 1; c <= 40; c++) begin
      rdy_in = !(stall_n > 0 && c >= stall_at && c < stall_at + stall_n);
      @(negedge clk);
      if (!rdy_in) begin
        if (ram_wr !== 1'b0) o_stall_wr++;
        if (if_done !== 1'b0 || mem_done !== 1'b0) o_wrong_done++;
      end else begin
        o_a.push_back(ram_a); o_wr.push_back(ram_wr); o_dout.push_back(ram_dout);
        if ((use_mem ? if_done : mem_done) !== 1'b0) o_wrong_done++;
        if ((use_mem ? mem_done : if_done) === 1'b1) begin
          o_lat = c; o_if_data = if_data; o_mem_rdata = mem_rdata;
          break;
        end
      end
      @(posedge clk); #1;
    end
    rdy_in = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy_in = 1'b0;
    if_req = 0; mem_req = 0; mem_we = 0; if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL reset_ram_wr got %b want 0", ram_wr); end
    n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL reset_if_done got %b want 0", if_done); end
    n_cmp++; if (mem_done !== 1'b0) begin n_bad++; $display("FAIL reset_mem_done got %b want 0", mem_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (ram_a !== 32'h0) begin n_bad++; $display("FAIL reset_ram_a got %h want 0", ram_a); end
    n_cmp++; if (ram_dout !== 8'h0) begin n_bad++; $display("FAIL reset_ram_dout got %h want 0", ram_dout); end
    n_cmp++; if (if_data !== 32'h0) begin n_bad++; $display("FAIL reset_if_data got %h want 0", if_data); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); end
    @(posedge clk); #1;
    rst = 1'b0; rdy_in = 1'b1;
    g_if = 32'h0; g_mem = 32'h0;
  endtask

  task automatic test_fetch;
    int bad;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h00; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    run_xfer(1'b0, 1'b0, 32'h100, 32'h0, 2'b11, 0, 0);
    g_if = 32'h0000_0013;
    n_cmp++; if (o_lat !== 6) begin n_bad++; $display("FAIL fetch_latency got %0d want 6", o_lat); end
    n_cmp++; if (o_if_data !== g_if) begin n_bad++; $display("FAIL fetch_data got %h want %h", o_if_data, g_if); end
    bad = (o_a.size() < 4) ? 1 : 0;
    for (int j = 0; j < 4 && j < o_a.size(); j++) if (o_a[j] !== 32'h100 + 32'(j)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL fetch_addr_seq got %0d bad want 0 bad", bad); end
    n_cmp++; if (o_wrong_done != 0) begin n_bad++; $display("FAIL fetch_wrong_done got %0d want 0", o_wrong_done); end
  endtask

  task automatic test_write;
    int bad;
    logic [31:0] wd;
    logic [31:0] got;
    wd = 32'hDEAD_BEEF;
    run_xfer(1'b1, 1'b1, 32'h200, wd, 2'b11, 0, 0);
    n_cmp++; if (o_lat !== 5) begin n_bad++; $display("FAIL write_latency got %0d want 5", o_lat); end
    bad = (o_a.size() != 5) ? 1 : 0;
    for (int j = 0; j < o_a.size(); j++) begin
      if (o_wr[j] !== (j < 4)) bad++;
      if (j < 4 && (o_a[j] !== 32'h200 + 32'(j) || o_dout[j] !== wd[8*j +: 8])) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL write_bus_seq got %0d bad want 0 bad", bad); end
    got = {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]};
    n_cmp++; if (got !== wd) begin n_bad++; $display("FAIL write_ram_bytes got %h want %h", got, wd); end
    n_cmp++; if (o_mem_rdata !== g_mem) begin n_bad++; $display("FAIL write_rdata_hold got %h want %h", o_mem_rdata, g_mem); end
  endtask

  task automatic test_wrap;
    ram[10'h3FF] = 8'hA5; ram[10'h000] = 8'h3C;
    run_xfer(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 2'b10, 0, 0);
    g_mem = 32'h0000_3CA5;
    n_cmp++; if (o_lat !== 4) begin n_bad++; $display("FAIL wrap_latency got %0d want 4", o_lat); end
    n_cmp++;
    if (o_a.size() < 2 || o_a[0] !== 32'hFFFF_FFFF || o_a[1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_addr_seq got %0d entries want FFFFFFFF then 0", o_a.size());
    end
    n_cmp++; if (o_mem_rdata !== g_mem) begin n_bad++; $display("FAIL wrap_data got %h want %h", o_mem_rdata, g_mem); end
    n_cmp++; if (o_if_data !== g_if) begin n_bad++; $display("FAIL wrap_if_hold got %h want %h", o_if_data, g_if); end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 4; i++) ram[10'h300 + 10'(i)] = 8'($urandom);
    g_mem = model_load(32'h300, 4);
    run_xfer(1'b1, 1'b0, 32'h300, 32'h0, 2'b11, 2, 3);
    n_cmp++; if (o_lat !== 9) begin n_bad++; $display("FAIL stall_latency got %0d want 9", o_lat); end
    n_cmp++; if (o_mem_rdata !== g_mem) begin n_bad++; $display("FAIL stall_data got %h want %h", o_mem_rdata, g_mem); end
    n_cmp++; if (o_stall_wr != 0) begin n_bad++; $display("FAIL stall_ram_wr got %0d want 0", o_stall_wr); end
  endtask

  task automatic test_random;
    bit use_mem, we;
    logic [1:0] len;
    logic [31:0] addr, wd, ld, ea;
    int n, st_n, st_at, exp_lat, bad;
    for (int t = 0; t < 40; t++) begin
      use_mem = 1'($urandom);
      we      = use_mem ? 1'($urandom) : 1'b0;
      len     = use_mem ? 2'($urandom) : 2'b11;
      addr    = $urandom;
      wd      = $urandom;
      n       = len_bytes(len);
      st_n    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
      st_at   = int'($urandom_range(1, n));
      ld      = model_load(addr, n);
      exp_lat = n + (we ? 1 : 2) + st_n;
      if (!we) begin
        if (use_mem) g_mem = ld;
        else         g_if = ld;
      end
      run_xfer(use_mem, we, addr, wd, len, st_at, st_n);
      n_cmp++;
      if (o_lat !== exp_lat) begin
        n_bad++; $display("FAIL rand%0d_latency got %0d want %0d", t, o_lat, exp_lat);
      end
      bad = (o_a.size() != exp_lat - st_n) ? 1 : 0;
      for (int j = 0; j < o_a.size(); j++) begin
        ea = addr + 32'((j < n) ? j : n - 1);
        if (o_a[j] !== ea) bad++;
        if (o_wr[j] !== (we && j < n)) bad++;
        if (we && j < n && o_dout[j] !== wd[8*j +: 8]) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL rand%0d_bus_trace got %0d bad want 0 bad", t, bad); end
      n_cmp++; if (o_if_data !== g_if) begin n_bad++; $display("FAIL rand%0d_if_data got %h want %h", t, o_if_data, g_if); end
      n_cmp++; if (o_mem_rdata !== g_mem) begin n_bad++; $display("FAIL rand%0d_mem_rdata got %h want %h", t, o_mem_rdata, g_mem); end
      n_cmp++; if (o_stall_wr != 0) begin n_bad++; $display("FAIL rand%0d_stall_wr got %0d want 0", t, o_stall_wr); end
      n_cmp++; if (o_wrong_done != 0) begin n_bad++; $display("FAIL rand%0d_wrong_done got %0d want 0", t, o_wrong_done); end
    end
  endtask

  task automatic test_arb;
    int order[$];
    int tdone[$];
    int exp;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h40;
    mem_len = 2'b01; rdy_in = 1'b1;
    for (int c = 0; c < 200 && order.size() < 6; c++) begin
      @(negedge clk);
      if (if_done === 1'b1) begin order.push_back(1); tdone.push_back(c); end
      else if (mem_done === 1'b1) begin order.push_back(0); tdone.push_back(c); end
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    n_cmp++; if (order.size() != 6) begin n_bad++; $display("FAIL arb_grant_count got %0d want 6", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp = (i == 4) ? 1 : 0;
`else
      exp = 0;
`endif
      n_cmp++;
      if (order[i] != exp) begin n_bad++; $display("FAIL arb_grant%0d got %0d want %0d (1=if)", i, order[i], exp); end
    end
    if (tdone.size() >= 2) begin
      n_cmp++;
      if (tdone[1] - tdone[0] != 4) begin
        n_bad++; $display("FAIL back_to_back_spacing got %0d want 4", tdone[1] - tdone[0]);
      end
    end
    for (int c = 0; c < 20 && busy !== 1'b0; c++) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arb_drain_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h280; mem_wdata = $urandom; mem_len = 2'b11;
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ram_wr !== 1'b1 || ram_a !== 32'h281) begin
      n_bad++; $display("FAIL rstmid_second_byte got wr=%b a=%h want wr=1 a=281", ram_wr, ram_a);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ram_wr !== 1'b0) begin n_bad++; $display("FAIL rstmid_ram_wr got %b want 0", ram_wr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++;
    if (mem_rdata !== 32'h0 || if_data !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_data_clear got %h/%h want 0/0", if_data, mem_rdata);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_done !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rstmid_no_done got %0d pulses want 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    test_reset();
    test_fetch();
    test_write();
    test_wrap();
    test_stall();
    test_random();
    test_arb();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
